// File: rtl/mips_pkg.sv
// mips_pkg: shared tracker entry type, constants and parameter range checks
// for the MIPS pipeline hazard/issue controller.
package mips_pkg;
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
  } trk_t;
  localparam int FWD_RF = 0;
  localparam logic [4:0] REG_ZERO = 5'd0;
  function automatic bit depth_ok(input int d);
    return d >= 1 && d <= 4;
  endfunction
  function automatic bit lat_ok(input int l);
    return l >= 2 && l <= 32;
  endfunction
  // $0 is hardwired, so a write to it never creates a dependency
  function automatic logic live(input trk_t e);
    return e.valid & e.we & (e.rd != REG_ZERO);
  endfunction
endpackage

// File: rtl/mips_muldiv_timer.sv
// mips_muldiv_timer: multiply/divide occupancy counter; busy while nonzero.
module mips_muldiv_timer
  import mips_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);
  localparam int CW = $clog2(MULDIV_LAT);
  logic [CW-1:0] cnt_q, cnt_d;
  if (!lat_ok(MULDIV_LAT)) begin : g_bad_lat
    $error("MULDIV_LAT must be 2..32");
  end
  always_comb cnt_d = load ? CW'(MULDIV_LAT - 1) : (cnt_q != '0 ? cnt_q - CW'(1) : cnt_q);
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign busy = cnt_q != '0;
endmodule

// File: rtl/mips_pipe_ctrl.sv
// mips_pipe_ctrl: in-flight write tracker, forwarding selects, stalls, flush and issue.
// Define MIPS_PIPE_FWD_EN for forwarding; otherwise any live dependency stalls.
module mips_pipe_ctrl
  import mips_pkg::*;
#(
  parameter int  DEPTH      = 2,
  parameter int  MULDIV_LAT = 4,
  localparam int FW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic          id_rs_used,
  input  logic          id_rt_used,
  input  logic [4:0]    id_rd,
  input  logic          id_we,
  input  logic          id_is_load,
  input  logic          id_is_muldiv,
  input  logic          id_reads_hilo,
  input  logic          ex_branch_taken,
  output logic          issue,
  output logic          id_stall,
  output logic          id_flush,
  output logic [FW-1:0] fwd_a,
  output logic [FW-1:0] fwd_b,
  output logic          busy
);
  trk_t          trk_q [DEPTH];
  trk_t          trk_d [DEPTH];
  logic          md_busy, load_use, dep_stall, raw_stall, hit_a, hit_b;
  logic [FW-1:0] fa, fb;
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("DEPTH must be 1..4");
  end
  mips_muldiv_timer #(.MULDIV_LAT(MULDIV_LAT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (issue & id_is_muldiv),
    .busy (md_busy)
  );
  always_comb begin
    load_use = live(trk_q[0]) & trk_q[0].is_load &
               ((id_rs_used & (trk_q[0].rd == id_rs)) | (id_rt_used & (trk_q[0].rd == id_rt)));
    fa = FW'(FWD_RF);
    fb = FW'(FWD_RF);
    dep_stall = 1'b0;
    hit_a = 1'b0;
    hit_b = 1'b0;
    // oldest first so the youngest match is the one left standing
    for (int k = DEPTH - 1; k >= 0; k--) begin
      hit_a = live(trk_q[k]) & id_rs_used & (trk_q[k].rd == id_rs);
      hit_b = live(trk_q[k]) & id_rt_used & (trk_q[k].rd == id_rt);
`ifdef MIPS_PIPE_FWD_EN
      if (hit_a && !(k == 0 && trk_q[k].is_load)) fa = FW'(k + 1);
      if (hit_b && !(k == 0 && trk_q[k].is_load)) fb = FW'(k + 1);
`else
      dep_stall = dep_stall | hit_a | hit_b;
`endif
    end
    raw_stall = id_valid & (load_use | dep_stall | (md_busy & (id_is_muldiv | id_reads_hilo)));
    issue     = rst & id_valid & !raw_stall & !ex_branch_taken;
    id_stall  = rst & raw_stall & !ex_branch_taken;
    id_flush  = rst & ex_branch_taken;
    fwd_a     = rst ? fa : '0;
    fwd_b     = rst ? fb : '0;
    busy      = rst & md_busy;
  end
  always_comb begin
    trk_d[0] = issue ? trk_t'{1'b1, id_rd, id_we, id_is_load} : trk_t'('0);
    for (int k = 1; k < DEPTH; k++) trk_d[k] = trk_q[k - 1];
  end
  always_ff @(posedge clk) begin
    if (!rst) trk_q <= '{default: '0};
    else trk_q <= trk_d;
  end
endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// tb_mips_pipe_ctrl: directed checks of issue/stall/flush/forward/busy for mips_pipe_ctrl.
// Expectations follow the MIPS_PIPE_FWD_EN build choice (DEPTH=2 with it, 3 without).
module tb_mips_pipe_ctrl;
`ifdef MIPS_PIPE_FWD_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 3;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid = 1'b0, id_rs_used = 1'b0, id_rt_used = 1'b0, id_we = 1'b0;
  logic id_is_load = 1'b0, id_is_muldiv = 1'b0, id_reads_hilo = 1'b0, ex_branch_taken = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic issue, id_stall, id_flush, busy;
  logic [1:0] fwd_a, fwd_b;
  logic [7:0] obs;
  int n_checks = 0;
  int n_fail = 0;

  mips_pipe_ctrl #(.DEPTH(DEPTH), .MULDIV_LAT(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
    .ex_branch_taken(ex_branch_taken), .issue(issue), .id_stall(id_stall),
    .id_flush(id_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .busy(busy)
  );

  always #5 clk = ~clk;
  assign obs = {issue, id_stall, id_flush, busy, fwd_a, fwd_b};

  // drive one decode-stage cycle at the falling edge, settle before checking
  task automatic put(input logic r, v, input logic [4:0] rs, rt, input logic rsu, rtu,
                     input logic [4:0] rd, input logic we, ld, md, hl, br);
    @(negedge clk);
    rst = r; id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_rd = rd; id_we = we; id_is_load = ld; id_is_muldiv = md; id_reads_hilo = hl;
    ex_branch_taken = br;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) put(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      put(0, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0);
      e = 8'b0000_0000;
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL reset_hold[%0d]: got %b want %b", i, obs, e); end
    end
    put(1, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0);
    e = 8'b1000_0000;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL reset_release: got %b want %b", obs, e); end
    idle(4);
  endtask

  task automatic test_dependency();
    logic [7:0] e;
    put(1, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0);
    e = 8'b1000_0000;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL dep_writer: got %b want %b", obs, e); end
`ifdef MIPS_PIPE_FWD_EN
    put(1, 1, 3, 4, 1, 1, 6, 1, 0, 0, 0, 0);
    e = 8'b1000_0100;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL fwd_entry0: got %b want %b", obs, e); end
    put(1, 1, 3, 0, 1, 0, 7, 1, 0, 0, 0, 0);
    e = 8'b1000_1000;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL fwd_entry1: got %b want %b", obs, e); end
`else
    for (int i = 0; i < 4; i++) begin
      put(1, 1, 3, 4, 1, 1, 6, 1, 0, 0, 0, 0);
      e = (i < 3) ? 8'b0100_0000 : 8'b1000_0000;
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL dep_stall[%0d]: got %b want %b", i, obs, e); end
    end
`endif
    idle(4);
  endtask

  task automatic test_zero_reg();
    logic [7:0] e;
    put(1, 1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0);
    e = 8'b1000_0000;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL zero_writer: got %b want %b", obs, e); end
    put(1, 1, 0, 2, 1, 1, 9, 1, 0, 0, 0, 0);
    e = 8'b1000_0000;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL zero_reader: got %b want %b", obs, e); end
    put(1, 1, 0, 9, 0, 1, 10, 1, 0, 0, 0, 0);
`ifdef MIPS_PIPE_FWD_EN
    e = 8'b1000_0001;
`else
    e = 8'b0100_0000;
`endif
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL rt_dependency: got %b want %b", obs, e); end
    idle(4);
  endtask

  task automatic test_load_use();
    logic [7:0] e;
    put(1, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0);
    e = 8'b1000_0000;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL lw_issue: got %b want %b", obs, e); end
    put(1, 1, 5, 6, 1, 1, 7, 1, 0, 0, 0, 0);
    e = 8'b0100_0000;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL load_use_stall: got %b want %b", obs, e); end
`ifdef MIPS_PIPE_FWD_EN
    put(1, 1, 5, 6, 1, 1, 7, 1, 0, 0, 0, 0);
    e = 8'b1000_1000;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL load_use_fwd: got %b want %b", obs, e); end
`else
    for (int i = 0; i < 3; i++) begin
      put(1, 1, 5, 6, 1, 1, 7, 1, 0, 0, 0, 0);
      e = (i < 2) ? 8'b0100_0000 : 8'b1000_0000;
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL load_dep[%0d]: got %b want %b", i, obs, e); end
    end
`endif
    idle(4);
  endtask

  task automatic test_muldiv();
    logic [7:0] e;
    put(1, 1, 8, 9, 1, 1, 0, 0, 0, 1, 0, 0);
    e = 8'b1000_0000;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL mult_issue: got %b want %b", obs, e); end
    for (int i = 0; i < 4; i++) begin
      put(1, 1, 0, 0, 0, 0, 10, 1, 0, 0, 1, 0);
      e = (i < 3) ? 8'b0101_0000 : 8'b1000_0000;
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL mflo[%0d]: got %b want %b", i, obs, e); end
    end
    put(1, 1, 8, 9, 1, 1, 0, 0, 0, 1, 0, 0);
    e = 8'b1000_0000;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL mult2_issue: got %b want %b", obs, e); end
    put(1, 1, 1, 2, 1, 1, 11, 1, 0, 0, 0, 0);
    e = 8'b1001_0000;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL addu_while_busy: got %b want %b", obs, e); end
    for (int i = 0; i < 3; i++) begin
      put(1, 1, 8, 9, 1, 1, 0, 0, 0, 1, 0, 0);
      e = (i < 2) ? 8'b0101_0000 : 8'b1000_0000;
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL b2b_mult[%0d]: got %b want %b", i, obs, e); end
    end
    idle(1);
    e = 8'b0001_0000;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL busy_idle: got %b want %b", obs, e); end
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e = 8'b0000_0000;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL busy_in_reset: got %b want %b", obs, e); end
    idle(1);
    e = 8'b0000_0000;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL busy_after_reset: got %b want %b", obs, e); end
    idle(4);
  endtask

  task automatic test_branch();
    logic [7:0] e;
    put(1, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0);
    e = 8'b1000_0000;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL br_lw_issue: got %b want %b", obs, e); end
    put(1, 1, 5, 6, 1, 1, 7, 1, 0, 0, 0, 1);
    e = 8'b0010_0000;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL br_over_load_use: got %b want %b", obs, e); end
    put(1, 1, 7, 0, 1, 0, 12, 1, 0, 0, 0, 0);
    e = 8'b1000_0000;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL br_bubble: got %b want %b", obs, e); end
    put(1, 1, 8, 9, 1, 1, 0, 0, 0, 1, 0, 1);
    e = 8'b0010_0000;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL br_over_mult: got %b want %b", obs, e); end
    idle(1);
    e = 8'b0000_0000;
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL br_mult_not_loaded: got %b want %b", obs, e); end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_dependency();
    test_zero_reg();
    test_load_use();
    test_muldiv();
    test_branch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
